// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_serializer_if
//  Description : Transmit-request / serial-line bundle between the string
//                transmission FSM (master) and uart_tx_serializer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_serializer_if;
    logic       transmit;         // level request to send tx_byte
    logic [7:0] tx_byte;          // byte to send, captured at accept
    logic       tx;               // serial line, idles high
    logic       is_transmitting;  // high from accept through end of stop bit
    logic       tx_done;          // one-cycle pulse when the stop bit completes

    modport master (
        output transmit,
        output tx_byte,
        input  tx,
        input  is_transmitting,
        input  tx_done
    );

    modport slave (
        input  transmit,
        input  tx_byte,
        output tx,
        output is_transmitting,
        output tx_done
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_serializer
//  Description : UART transmit serializer. Sends one byte per request as an
//                8N1 frame (start, 8 data bits LSB first, stop). Each bit lasts
//                CLKS_PER_BIT clock cycles. All outputs are registered.
//                Optional macro UART_TX_PARITY_EN inserts an even-parity bit
//                between the data bits and the stop bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  wire logic             clk,
    input  wire logic             reset,   // asynchronous, active-low
    uart_tx_serializer_if.slave   bus
);

    localparam int                C_CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    logic [C_CNT_W-1:0]   r_baud_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;

    // Terminal count of the baud counter marks the last cycle of the current bit.
    logic w_bit_end;
    assign w_bit_end = (r_baud_cnt == C_CNT_LAST);

    // Frame sequencer: baud timing, bit shifting and registered line outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Counter only runs inside a frame; it wraps to 0 at each bit end,
            // so it is already 0 when the frame returns to idle.
            if (r_state != S_IDLE) begin
                r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.transmit) begin
                        r_shift    <= bus.tx_byte;
`ifdef UART_TX_PARITY_EN
                        r_parity   <= ^bus.tx_byte;
`endif
                        r_bit_idx  <= '0;
                        r_baud_cnt <= '0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            // Next data bit is the one about to land in shift[0].
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
`endif

                S_STOP: begin
                    // A request still pending here is only seen once back in idle.
                    if (w_bit_end) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_tx       <= 1'b1;
                    r_busy     <= 1'b0;
                    r_baud_cnt <= '0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx              = r_tx;
    assign bus.is_transmitting = r_busy;
    assign bus.tx_done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_serializer
//  Description : Self-checking bench for uart_tx_serializer (CLKS_PER_BIT=4).
//                Table vectors, hand-written corner sequences and random bytes
//                checked cycle by cycle against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic clk;
    logic reset;
    uart_tx_serializer_if bus();

    uart_tx_serializer #(.CLKS_PER_BIT(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] word;   // 8N1 frame, bit 0 first on the line
        logic       par;    // even parity of data
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Frame as it appears on the line, element 0 first: start, data LSB first,
    // optional even parity, stop. Unused top bit is 0.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        f = '0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        if (FB == 11) begin
            f[9]  = (ones % 2 == 1);
            f[10] = 1'b1;
        end else begin
            f[9]  = 1'b1;
        end
        return f;
    endfunction

    function automatic logic [10:0] table_frame(input vec_t v);
        logic [10:0] f;
        if (FB == 11) f = {1'b1, v.par, v.word[8:0]};
        else          f = {1'b0, v.word};
        return f;
    endfunction

    // Called just after the accept edge; checks every cycle of the frame and
    // returns just after the edge where is_transmitting falls.
    task automatic check_frame(input logic [10:0] exp, input bit poke);
        for (int c = 0; c < FB*N; c++) begin
            check("tx_bit",   32'(bus.tx), 32'(exp[c/N]));
            check("busy",     32'(bus.is_transmitting), 32'd1);
            check("done_low", 32'(bus.tx_done), 32'd0);
            if (poke && c == 3*N) begin
                bus.transmit = 1'b1;
                bus.tx_byte  = 8'h42;
            end
            if (poke && c == 3*N+1) bus.transmit = 1'b0;
            @(posedge clk); #1;
        end
        check("busy_fall",  32'(bus.is_transmitting), 32'd0);
        check("done_pulse", 32'(bus.tx_done), 32'd1);
        check("tx_stop_idle", 32'(bus.tx), 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic [10:0] exp, input bit poke);
        bus.transmit = 1'b1;
        bus.tx_byte  = d;
        @(posedge clk); #1;
        bus.transmit = 1'b0;
        bus.tx_byte  = 8'($urandom);
        check_frame(exp, poke);
        @(posedge clk); #1;
        check("done_clear", 32'(bus.tx_done), 32'd0);
        check("no_restart", 32'(bus.is_transmitting), 32'd0);
        check("line_idle",  32'(bus.tx), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle_tx",   32'(bus.tx), 32'd1);
            check("idle_busy", 32'(bus.is_transmitting), 32'd0);
        end
    endtask

    initial begin
        vec_t vecs [8];
        logic [7:0] rb;

        vecs[0] = '{8'h48, 10'h290, 1'b0};
        vecs[1] = '{8'h41, 10'h282, 1'b0};
        vecs[2] = '{8'h00, 10'h200, 1'b0};
        vecs[3] = '{8'hFF, 10'h3FE, 1'b0};
        vecs[4] = '{8'h55, 10'h2AA, 1'b0};
        vecs[5] = '{8'h07, 10'h20E, 1'b1};
        vecs[6] = '{8'hA5, 10'h34A, 1'b0};
        vecs[7] = '{8'h80, 10'h300, 1'b1};

        // Reset held with a pending request: line stays idle.
        reset        = 1'b0;
        bus.transmit = 1'b1;
        bus.tx_byte  = 8'h48;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("rst_tx",   32'(bus.tx), 32'd1);
            check("rst_busy", 32'(bus.is_transmitting), 32'd0);
            check("rst_done", 32'(bus.tx_done), 32'd0);
        end
        reset = 1'b1;
        // Request is still high: frame starts on the first edge after release.
        send(8'h48, table_frame(vecs[0]), 1'b0);

        // Table-driven frames; vector 1 also gets a mid-frame request that must be ignored.
        for (int i = 0; i < 8; i++) begin
            idle_cycles(1);
            send(vecs[i].data, table_frame(vecs[i]), i == 1);
        end

        // Request held continuously, byte changed mid-frame.
        idle_cycles(2);
        bus.transmit = 1'b1;
        bus.tx_byte  = 8'h48;
        @(posedge clk); #1;
        bus.tx_byte  = 8'h65;
        check_frame(model_frame(8'h48), 1'b0);
        @(posedge clk); #1;
        bus.transmit = 1'b0;
        check_frame(model_frame(8'h65), 1'b0);
        @(posedge clk); #1;
        check("hold_done_clear", 32'(bus.tx_done), 32'd0);
        idle_cycles(2);

        // Reset during data bit 3 of 8'hFF aborts the frame asynchronously.
        bus.transmit = 1'b1;
        bus.tx_byte  = 8'hFF;
        @(posedge clk); #1;
        bus.transmit = 1'b0;
        repeat (4*N + 1) @(posedge clk);
        #2;
        check("pre_abort_busy", 32'(bus.is_transmitting), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_tx",   32'(bus.tx), 32'd1);
        check("abort_busy", 32'(bus.is_transmitting), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle_cycles(3);
        send(8'h55, model_frame(8'h55), 1'b0);

        // Random bytes against the frame model, random idle gaps.
        for (int i = 0; i < 12; i++) begin
            idle_cycles($urandom_range(0, 3));
            rb = 8'($urandom);
            send(rb, model_frame(rb), (i % 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
